// File: rtl/yuv422_to_rgb.sv
// yuv422_to_rgb: converts packed 4-pixel full-swing YUV422 words into 4-pixel
// RGB at 10 bit per colour. The datapath has three stages (chroma offset,
// multiply, sum/clamp/expand), each with its own valid bit. Every stage
// advances together, so bubbles are carried through rather than collapsed.
// A saturating counter records how many transferred words had any component
// clamped.
module yuv422_to_rgb #(
    parameter int PIXEL_DEPTH   = 10,
    parameter int PIXEL_PER_CLK = 4,
    parameter int CLIP_CNT_W    = 16
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [16*PIXEL_PER_CLK-1:0]              yuv_i,
    input  logic                                     yuv_valid_i,
    output logic                                     yuv_ready_o,
    output logic [3*PIXEL_DEPTH*PIXEL_PER_CLK-1:0]   rgb_o,
    output logic                                     rgb_valid_o,
    input  logic                                     rgb_ready_i,
    input  logic                                     clip_clr_i,
    output logic [CLIP_CNT_W-1:0]                    clip_count_o
);

    localparam int RGB_W = 3 * PIXEL_DEPTH * PIXEL_PER_CLK;

    // Sign-extend a 9-bit two's-complement chroma value to 18 bits.
    function automatic logic signed [17:0] sx9(input logic [8:0] a);
        return {{9{a[8]}}, a};
    endfunction

    // Zero-extend an 8-bit luma value to a signed 18-bit operand.
    function automatic logic signed [17:0] zx8(input logic [7:0] a);
        return {10'd0, a};
    endfunction

    // Clamp to 0..255. Bit 8 of the result flags that clamping occurred.
    function automatic logic [8:0] clamp8(input logic signed [17:0] x);
        if (x < 18'sd0) begin
            return {1'b1, 8'h00};
        end else if (x > 18'sd255) begin
            return {1'b1, 8'hff};
        end else begin
            return {1'b0, x[7:0]};
        end
    endfunction

    // Widen to 10 bits by repeating the top bits, so that 255 maps to 1023.
    function automatic logic [9:0] expand10(input logic [7:0] c);
        return {c, c[7:6]};
    endfunction

    logic               adv;

    logic               s1_valid;
    logic [7:0]         s1_y [4];
    logic [8:0]         s1_u [2];
    logic [8:0]         s1_v [2];

    logic               s2_valid;
    logic [7:0]         s2_y  [4];
    logic signed [17:0] s2_pr [2];
    logic signed [17:0] s2_pg [2];
    logic signed [17:0] s2_pb [2];

    logic [RGB_W-1:0]   rgb_next;
    logic               clip_next;
    logic               clip_q;
    logic [8:0]         c_r;
    logic [8:0]         c_g;
    logic [8:0]         c_b;

    // All stages move together whenever the output register is empty or draining.
    assign adv         = !rgb_valid_o || rgb_ready_i;
    assign yuv_ready_o = adv;

    // S1: capture luma and remove the 128 chroma offset (U/V shared by pixel pairs).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < 4; i++) s1_y[i] <= '0;
            for (int c = 0; c < 2; c++) begin
                s1_u[c] <= '0;
                s1_v[c] <= '0;
            end
        end else if (adv) begin
            s1_valid <= yuv_valid_i;
            s1_y[0]  <= yuv_i[63:56];
            s1_y[1]  <= yuv_i[47:40];
            s1_y[2]  <= yuv_i[31:24];
            s1_y[3]  <= yuv_i[15:8];
            s1_u[0]  <= {1'b0, yuv_i[55:48]} - 9'd128;
            s1_v[0]  <= {1'b0, yuv_i[39:32]} - 9'd128;
            s1_u[1]  <= {1'b0, yuv_i[23:16]} - 9'd128;
            s1_v[1]  <= {1'b0, yuv_i[7:0]}   - 9'd128;
        end
    end

    // S2: chroma products; 18-bit signed holds the worst case (454*-128) without wrap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < 4; i++) s2_y[i] <= '0;
            for (int c = 0; c < 2; c++) begin
                s2_pr[c] <= '0;
                s2_pg[c] <= '0;
                s2_pb[c] <= '0;
            end
        end else if (adv) begin
            s2_valid <= s1_valid;
            for (int i = 0; i < 4; i++) s2_y[i] <= s1_y[i];
            for (int c = 0; c < 2; c++) begin
                s2_pr[c] <= sx9(s1_v[c]) * 18'sd359;
                s2_pg[c] <= sx9(s1_u[c]) * 18'sd88 + sx9(s1_v[c]) * 18'sd183;
                s2_pb[c] <= sx9(s1_u[c]) * 18'sd454;
            end
        end
    end

    // S3 combinational part: round, add luma, clamp, widen and collect the clip flag.
    always_comb begin
        rgb_next  = '0;
        clip_next = 1'b0;
        c_r       = '0;
        c_g       = '0;
        c_b       = '0;
        for (int p = 0; p < 4; p++) begin
            c_r = clamp8(zx8(s2_y[p]) + ((s2_pr[p/2] + 18'sd128) >>> 8));
            c_g = clamp8(zx8(s2_y[p]) - ((s2_pg[p/2] + 18'sd128) >>> 8));
            c_b = clamp8(zx8(s2_y[p]) + ((s2_pb[p/2] + 18'sd128) >>> 8));
            rgb_next[RGB_W-1 - 30*p -: 10] = expand10(c_r[7:0]);
            rgb_next[RGB_W-11 - 30*p -: 10] = expand10(c_g[7:0]);
            rgb_next[RGB_W-21 - 30*p -: 10] = expand10(c_b[7:0]);
            clip_next = clip_next | c_r[8] | c_g[8] | c_b[8];
        end
    end

    // S3 register: output word, its valid, and its clip flag (gated so bubbles never count).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rgb_o       <= '0;
            rgb_valid_o <= 1'b0;
            clip_q      <= 1'b0;
        end else if (adv) begin
            rgb_o       <= rgb_next;
            rgb_valid_o <= s2_valid;
            clip_q      <= s2_valid & clip_next;
        end
    end

    // Clip counter: clear wins over increment; saturates at all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clip_count_o <= '0;
        end else if (clip_clr_i) begin
            clip_count_o <= '0;
        end else if (rgb_valid_o && rgb_ready_i && clip_q && !(&clip_count_o)) begin
            clip_count_o <= clip_count_o + {{(CLIP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
